// File: rtl/shfr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : shfr_seq
//  Description : Sequential right-shift unit. Shifts bus a right by the
//                1-based index of the least significant '1' on bus b. If b is
//                zero, a is passed through unchanged. The unit moves one bit
//                position per clock and uses valid/ready handshakes on both
//                its input and its output.
//
//                Optional build macro:
//                  SHFR_ARITH_EN - when defined, the shift is arithmetic and
//                                  the vacated MSB is filled with the sign
//                                  bit. When undefined, the shift is logical
//                                  and the vacated MSB is zero-filled.
//
//  Ports       : clk        - clock, rising edge
//                rst_n      - asynchronous active-low reset
//                in_valid   - operands valid
//                in_ready   - unit idle, can accept operands
//                a          - data bus to be shifted
//                b          - shift-amount bus (LS '1' selects the amount)
//                out_valid  - result valid
//                out_ready  - consumer accepts result
//                result     - shifted data
//                shamt      - shift amount applied (0 when b == 0)
//                busy       - high while shifting
//
//  Revision    : 1.0 - initial release
// ============================================================================
module shfr_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [SHW-1:0]   shamt,
    output logic             busy
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_result;
    logic [SHW-1:0]   r_shamt;

    logic             w_accept;
    logic             w_fill;
    logic [WIDTH-1:0] w_a_shr;
    logic [SHW-1:0]   w_cnt_inc;

    assign w_accept  = in_valid && (r_state == c_st_idle);

`ifdef SHFR_ARITH_EN
    assign w_fill    = r_a[WIDTH-1];
`else
    assign w_fill    = 1'b0;
`endif

    assign w_a_shr   = {w_fill, r_a[WIDTH-1:1]};
    assign w_cnt_inc = r_cnt + SHW'(1);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (in_valid) begin
                    w_state_nxt = (b == '0) ? c_st_done : c_st_shift;
                end
            end
            c_st_shift: begin
                // The edge that shifts out the LS '1' of b is the last one.
                if (r_b[0]) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                if (out_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            c_st_idle:  in_ready  = 1'b1;
            c_st_shift: busy      = 1'b1;
            c_st_done:  out_valid = 1'b1;
            default:    in_ready  = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath. result/shamt have their own registers so that they hold the
    // last delivered value across IDLE, even after r_a is reloaded by a new
    // accept; they are written only on the edge that enters DONE.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_shamt  <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_cnt <= '0;
            if (b == '0) begin
                r_result <= a;
                r_shamt  <= '0;
            end
        end else if (r_state == c_st_shift) begin
            r_a   <= w_a_shr;
            r_b   <= r_b >> 1;
            r_cnt <= w_cnt_inc;
            if (r_b[0]) begin
                r_result <= w_a_shr;
                r_shamt  <= w_cnt_inc;
            end
        end
    end

    assign result = r_result;
    assign shamt  = r_shamt;

endmodule
`default_nettype wire

// File: tb/tb_shfr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shfr_seq
//  Description : Self-checking bench for shfr_seq. A behavioural model derives
//                the expected shift amount and result from the operands and
//                tracks the expected handshake phase; a compare process checks
//                every cycle, and directed operations pin literal results and
//                latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shfr_seq;

    localparam int WIDTH = 32;
    localparam int SHW   = $clog2(WIDTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [SHW-1:0]   shamt;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    shfr_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .shamt     (shamt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference arithmetic
    // ------------------------------------------------------------------------
    function automatic int lsb_shift(input logic [WIDTH-1:0] bv);
        for (int i = 0; i < WIDTH; i++) begin
            if (bv[i]) return i + 1;
        end
        return 0;
    endfunction

    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] av, input int s);
`ifdef SHFR_ARITH_EN
        return WIDTH'($signed(av) >>> s);
`else
        return av >> s;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: phase 0 idle, 1 working (m_rem cycles left), 2 done
    // ------------------------------------------------------------------------
    int               m_phase;
    int               m_rem;
    int               m_pend_sh;
    logic [WIDTH-1:0] m_pend_a;
    logic [WIDTH-1:0] m_res;
    int               m_sh;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase   <= 0;
            m_rem     <= 0;
            m_pend_sh <= 0;
            m_pend_a  <= '0;
            m_res     <= '0;
            m_sh      <= 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    if (lsb_shift(b) == 0) begin
                        m_phase <= 2;
                        m_res   <= a;
                        m_sh    <= 0;
                    end else begin
                        m_phase   <= 1;
                        m_rem     <= lsb_shift(b);
                        m_pend_sh <= lsb_shift(b);
                        m_pend_a  <= a;
                    end
                end
                1: begin
                    m_rem <= m_rem - 1;
                    if (m_rem == 1) begin
                        m_phase <= 2;
                        m_res   <= ref_shift(m_pend_a, m_pend_sh);
                        m_sh    <= m_pend_sh;
                    end
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("in_ready",  {31'd0, in_ready},  {31'd0, m_phase == 0});
        check("busy",      {31'd0, busy},      {31'd0, m_phase == 1});
        check("out_valid", {31'd0, out_valid}, {31'd0, m_phase == 2});
        check("result",    result,             m_res);
        check("shamt",     {26'd0, shamt},     m_sh);
    end

    // ------------------------------------------------------------------------
    // Directed operation with literal expectations
    // ------------------------------------------------------------------------
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_r, input int exp_s,
                          input int exp_lat, input int hold, input bit keep_valid);
        int lat;
        @(negedge clk);
        a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        if (keep_valid) begin
            a = 32'hAAAA_5555; b = 32'h0000_0001;
        end else begin
            in_valid = 1'b0; a = $urandom; b = $urandom;
        end
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("op_result", result, exp_r);
        check("op_shamt", {26'd0, shamt}, exp_s);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_result", result, exp_r);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_result_kept", result, exp_r);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", result, 32'd0);
        check("rst_shamt", {26'd0, shamt}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);

`ifdef SHFR_ARITH_EN
        run_op(32'h8000_0000, 32'h0000_0004, 32'hF000_0000, 3, 4, 0, 1'b0);
        run_op(32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 0, 1, 0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32, 33, 0, 1'b0);
        run_op(32'hF0F0_F0F0, 32'h0000_0006, 32'hFC3C_3C3C, 2, 3, 0, 1'b1);
        run_op(32'hDEAD_BEEF, 32'hFFFF_0010, 32'hFEF5_6DF7, 5, 6, 5, 1'b0);
`else
        run_op(32'h8000_0000, 32'h0000_0004, 32'h1000_0000, 3, 4, 0, 1'b0);
        run_op(32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 0, 1, 0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32, 33, 0, 1'b0);
        run_op(32'hF0F0_F0F0, 32'h0000_0006, 32'h3C3C_3C3C, 2, 3, 0, 1'b1);
        run_op(32'hDEAD_BEEF, 32'hFFFF_0010, 32'h06F5_6DF7, 5, 6, 5, 1'b0);
`endif

        // Reset during the third SHIFT cycle discards the operation
        @(negedge clk);
        a = 32'h0000_0001; b = 32'h0000_0100; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check("no_stale_valid", {31'd0, out_valid}, 32'd0);
        end
        run_op(32'h0000_0008, 32'h0000_0001, 32'h0000_0004, 1, 2, 0, 1'b0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shfr_seq.md
Name: shfr_seq

Overview:
- Sequential right-shift unit; the reverse-direction companion to the combinational left-shift ALU op.
- Shifts bus A right by the 1-based index of the least significant '1' on bus B.
  - bit 0 set -> shift 1; bit k set -> shift k+1.
  - B == 0 -> A is passed unchanged.
- Iterative: one bit position per clock, with valid/ready handshakes on input and output.
- Sits in the execute stage as a multi-cycle ALU op; the pipeline stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, data width of A, B and result.
- SHW, $clog2(WIDTH)+1, width of the reported shift amount (holds values 0..WIDTH).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  unit idle; can accept operands.
- a  input  WIDTH  bus to be shifted.
- b  input  WIDTH  shift-amount bus.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  shifted data.
- shamt  output  SHW  shift amount applied (0 when b == 0).
- busy  output  1  high in SHIFT state.

Behaviour:
- Reset: rst_n low asynchronously clears all state. The block returns to IDLE with out_valid=0, result=0, shamt=0, busy=0. Internal a_r, b_r and cnt are cleared to 0.
- in_ready = (state==IDLE), combinational from state. After reset release, in_ready=1.
- States:
  - IDLE: on in_valid && in_ready, load a_r=a, b_r=b, cnt=0.
    - b==0 -> DONE.
    - otherwise -> SHIFT.
  - SHIFT: every edge: a_r <= a_r>>1 (logical, zero fill), b_r <= b_r>>1, cnt <= cnt+1. If b_r[0] was 1 on that edge, go to DONE. This gives exactly shamt edges in SHIFT.
  - DONE: out_valid=1; result=a_r; shamt=cnt. Hold stable until out_ready. On out_valid && out_ready -> IDLE.
- Latency:
  - out_valid rises shamt+1 cycles after the accept cycle. For b==0 this is 1 cycle.
  - Maximum latency is WIDTH+1 cycles, when only b[WIDTH-1] is set; result is then 0.
- Only the least significant '1' of b matters; higher bits are ignored.
- No back-to-back acceptance: a new operand is taken only in IDLE, so at most one op is in flight.
- in_valid while not in_ready: ignored. The producer must hold its operands.
- a/b changes after acceptance: no effect, because operands are registered.
- out_ready high before DONE: no effect.
- Reset mid-SHIFT or mid-DONE: the op is discarded, out_valid drops immediately, and no result is produced.
- result and shamt are only meaningful while out_valid=1. They keep their last value after the handshake until the next DONE.

Optional Feature:
- Macro: SHFR_ARITH_EN.
- Defined: SHIFT fills the vacated MSB with a_r[WIDTH-1] (arithmetic shift). A negative A saturates to all ones when shamt=WIDTH.
- Undefined: logical shift with zero fill; no extra logic.

Test Plan:
- WIDTH=32, a=0x80000000, b=0x00000004 -> out_valid 4 cycles after accept; result=0x10000000, shamt=3.
- a=0x12345678, b=0x00000000 -> out_valid 1 cycle after accept; result=0x12345678, shamt=0.
- a=0xFFFFFFFF, b=0x80000000 -> out_valid 33 cycles after accept; result=0x00000000 (0xFFFFFFFF with SHFR_ARITH_EN), shamt=32.
- a=0xF0F0F0F0, b=0x00000006 (LS one at bit 1) -> result=0x3C3C3C3C, shamt=2. Test in_valid held high with new operands during SHIFT -> they are not accepted until return to IDLE.
- Hold out_ready=0 for 5 cycles in DONE -> result and out_valid stay stable; out_ready=1 -> IDLE next cycle, in_ready=1.
- a=0x1, b=0x100; pulse rst_n low on the 3rd SHIFT cycle -> out_valid=0, in_ready=1 after release, no stale result emitted; the next op (a=0x8, b=0x1) gives result=0x4.
